// File: rtl/alu_pkg.sv
// Shared ALU control codes and datapath width constants for the execute stage.
package alu_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_MUL = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001
    } alu_ctrl_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Forwarding compare/select for one source register; MEM beats WB, r0 never forwards.
module operand_fwd_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src_addr,
    input  logic [DW-1:0] held_data,
    input  logic          mem_reg_write,
    input  logic          mem_mem_read,
    input  logic [RW-1:0] mem_dest,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dest,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] fwd_data
);

    always_comb begin
        fwd_data = held_data;
        // A load in MEM has no data yet; that case is covered by the load-use bubble.
        if ((src_addr != '0) && mem_reg_write && !mem_mem_read && (mem_dest == src_addr)) begin
            fwd_data = mem_result;
        end else if ((src_addr != '0) && wb_reg_write && (wb_dest == src_addr)) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU with MEM/WB forwarding and load-use bubbles.
// Optional EX_STALL_CNT_EN adds a saturating stall_cnt output of load-use cycles.
module ex_operand_stage #(
    parameter int unsigned DW = alu_pkg::DW,
    parameter int unsigned RW = alu_pkg::RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [3:0]    id_alu_control,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_dest,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_use_imm,
    input  logic          id_shift,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [3:0]    ex_alu_control,
    output logic [DW-1:0] ex_scr_a,
    output logic [DW-1:0] ex_scr_b,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    input  logic          mem_reg_write,
    input  logic          mem_mem_read,
    input  logic [RW-1:0] mem_dest,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dest,
    input  logic [DW-1:0] wb_result
`ifdef EX_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    import alu_pkg::*;

    logic          v_q, v_d;
    alu_ctrl_e     alu_control_q, alu_control_d;
    logic [RW-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, dest_q, dest_d;
    logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [4:0]    shamt_q, shamt_d;
    logic          use_imm_q, use_imm_d, shift_q, shift_d;
    logic          reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;

    logic [DW-1:0] fwd_rs, fwd_rt;
    logic          load_use, leaving, accept;

    operand_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src_addr(rs_addr_q), .held_data(rs_data_q),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
        .fwd_data(fwd_rs)
    );

    operand_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src_addr(rt_addr_q), .held_data(rt_data_q),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
        .fwd_data(fwd_rt)
    );

    always_comb begin
        // Shift forms never read rs, so a load into rs must not stall them.
        load_use = v_q & mem_reg_write & mem_mem_read & (mem_dest != '0) &
                   ((!shift_q & (mem_dest == rs_addr_q)) | (mem_dest == rt_addr_q));
        ex_valid = v_q & !load_use;
        leaving  = ex_valid & ex_ready;
        id_ready = !v_q | (ex_ready & !load_use);
        accept   = id_valid & id_ready & !flush;

        ex_alu_control = alu_control_q;
        ex_scr_a       = shift_q ? fwd_rt : fwd_rs;
        ex_scr_b       = shift_q ? {{(DW-5){1'b0}}, shamt_q} : (use_imm_q ? imm_q : fwd_rt);
        ex_store_data  = fwd_rt;
        ex_dest        = dest_q;
        ex_reg_write   = reg_write_q;
        ex_mem_read    = mem_read_q;
        ex_mem_write   = mem_write_q;
    end

    always_comb begin
        v_d           = v_q;
        alu_control_d = alu_control_q;
        rs_addr_d     = rs_addr_q;
        rt_addr_d     = rt_addr_q;
        dest_d        = dest_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        imm_d         = imm_q;
        shamt_d       = shamt_q;
        use_imm_d     = use_imm_q;
        shift_d       = shift_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        if (accept) begin
            v_d           = 1'b1;
            alu_control_d = alu_ctrl_e'(id_alu_control);
            rs_addr_d     = id_rs_addr;
            rt_addr_d     = id_rt_addr;
            dest_d        = id_dest;
            rs_data_d     = id_rs_data;
            rt_data_d     = id_rt_data;
            imm_d         = id_imm;
            shamt_d       = id_shamt;
            use_imm_d     = id_use_imm;
            shift_d       = id_shift;
            reg_write_d   = id_reg_write;
            mem_read_d    = id_mem_read;
            mem_write_d   = id_mem_write;
        end else if (leaving) begin
            v_d = 1'b0;
        end else if (v_q) begin
            // Capture forwarded values so a stall outlives the producer's visibility.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end
        if (flush) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q           <= 1'b0;
            alu_control_q <= ALU_AND;
            rs_addr_q     <= '0;
            rt_addr_q     <= '0;
            dest_q        <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            use_imm_q     <= 1'b0;
            shift_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            v_q           <= v_d;
            alu_control_q <= alu_control_d;
            rs_addr_q     <= rs_addr_d;
            rt_addr_q     <= rt_addr_d;
            dest_q        <= dest_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_q         <= imm_d;
            shamt_q       <= shamt_d;
            use_imm_q     <= use_imm_d;
            shift_q       <= shift_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

`ifdef EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage (EX_STALL_CNT_EN checks when defined).
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [3:0]  id_alu_control;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dest;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_use_imm, id_shift, id_reg_write, id_mem_read, id_mem_write;
    logic        flush, ex_ready, ex_valid;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_scr_a, ex_scr_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_reg_write, mem_mem_read;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_result;
`ifdef EX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_control(id_alu_control),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_use_imm(id_use_imm), .id_shift(id_shift),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_alu_control(ex_alu_control),
        .ex_scr_a(ex_scr_a), .ex_scr_b(ex_scr_b), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result)
`ifdef EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [3:0] alu, input logic [4:0] rs, input logic [31:0] rsd,
                              input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] dst,
                              input logic [31:0] imm, input logic [4:0] sh,
                              input logic use_imm, input logic shift);
        id_valid       = 1'b1;
        id_alu_control = alu;
        id_rs_addr     = rs;
        id_rs_data     = rsd;
        id_rt_addr     = rt;
        id_rt_data     = rtd;
        id_dest        = dst;
        id_imm         = imm;
        id_shamt       = sh;
        id_use_imm     = use_imm;
        id_shift       = shift;
        id_reg_write   = 1'b1;
        id_mem_read    = 1'b0;
        id_mem_write   = 1'b0;
    endtask

    task automatic clear_fwd();
        mem_reg_write = 1'b0;
        mem_mem_read  = 1'b0;
        mem_dest      = '0;
        mem_result    = '0;
        wb_reg_write  = 1'b0;
        wb_dest       = '0;
        wb_result     = '0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        load_instr(4'b0000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);
        id_valid = 1'b0;
        id_reg_write = 1'b0;
        clear_fwd();
        step();
        step();

        // Reset state
        check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_id_ready", {31'b0, id_ready}, 32'h1);
        check("rst_reg_write", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'h0);
        check("rst_alu_ctrl", {28'b0, ex_alu_control}, 32'h0);
        check("rst_scr_a", ex_scr_a, 32'h0);
        check("rst_scr_b", ex_scr_b, 32'h0);
        check("rst_dest", {27'b0, ex_dest}, 32'h0);
`ifdef EX_STALL_CNT_EN
        check("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
`endif
        reset = 1'b0;

        // Plain ADD
        load_instr(4'b0010, 5'd3, 32'd5, 5'd4, 32'd7, 5'd8, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        #1;
        check("add_ex_valid", {31'b0, ex_valid}, 32'h1);
        check("add_scr_a", ex_scr_a, 32'd5);
        check("add_scr_b", ex_scr_b, 32'd7);
        check("add_alu_ctrl", {28'b0, ex_alu_control}, 32'h2);
        check("add_dest", {27'b0, ex_dest}, 32'd8);
        check("add_reg_write", {31'b0, ex_reg_write}, 32'h1);
        check("add_store", ex_store_data, 32'd7);

        // MEM beats WB; ADD leaves as SUB is accepted
        load_instr(4'b0110, 5'd2, 32'h99, 5'd0, 32'h0, 5'd1, 32'h1234, 5'd0, 1'b1, 1'b0);
        step();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        mem_reg_write = 1'b1; mem_dest = 5'd2; mem_result = 32'h10;
        wb_reg_write = 1'b1;  wb_dest = 5'd2;  wb_result = 32'h20;
        #1;
        check("fwd_mem_prio", ex_scr_a, 32'h10);
        check("fwd_imm_b", ex_scr_b, 32'h1234);
        check("fwd_alu_sub", {28'b0, ex_alu_control}, 32'h6);
        mem_reg_write = 1'b0;
        #1;
        check("fwd_wb", ex_scr_a, 32'h20);
        wb_reg_write = 1'b0;
        #1;
        check("fwd_held", ex_scr_a, 32'h99);

        // Register 0 is never forwarded
        load_instr(4'b0001, 5'd0, 32'h77, 5'd0, 32'h66, 5'd1, 32'h0, 5'd0, 1'b0, 1'b0);
        ex_ready = 1'b1;
        step();
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_dest = 5'd0; mem_result = 32'h10;
        wb_reg_write = 1'b1;  wb_dest = 5'd0;  wb_result = 32'h20;
        #1;
        check("r0_scr_a", ex_scr_a, 32'h77);
        check("r0_scr_b", ex_scr_b, 32'h66);
        check("r0_valid", {31'b0, ex_valid}, 32'h1);
        clear_fwd();
        step();
        check("drain_valid", {31'b0, ex_valid}, 32'h0);

        // Load-use on rt for two cycles, then WB supplies the data
        load_instr(4'b0010, 5'd1, 32'h01, 5'd6, 32'h06, 5'd2, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dest = 5'd6; mem_result = 32'hDEAD;
        #1;
        check("lu_valid_0", {31'b0, ex_valid}, 32'h0);
        check("lu_ready_0", {31'b0, id_ready}, 32'h0);
        step();
        check("lu_valid_1", {31'b0, ex_valid}, 32'h0);
        check("lu_no_mem_fwd", ex_scr_b, 32'h06);
        step();
        clear_fwd();
        wb_reg_write = 1'b1; wb_dest = 5'd6; wb_result = 32'hAB;
        #1;
        check("lu_rel_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_rel_ready", {31'b0, id_ready}, 32'h1);
        check("lu_rel_scr_b", ex_scr_b, 32'hAB);
        check("lu_rel_store", ex_store_data, 32'hAB);
        check("lu_rel_scr_a", ex_scr_a, 32'h01);
`ifdef EX_STALL_CNT_EN
        check("stall_cnt_2", {16'b0, stall_cnt}, 32'd2);
`endif
        clear_fwd();
        step();

        // Back-pressure: WB forwards only in the first stalled cycle
        load_instr(4'b0010, 5'd5, 32'h11, 5'd7, 32'h22, 5'd3, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        wb_reg_write = 1'b1; wb_dest = 5'd5; wb_result = 32'h55;
        #1;
        check("bp_c1_scr_a", ex_scr_a, 32'h55);
        check("bp_c1_valid", {31'b0, ex_valid}, 32'h1);
        check("bp_c1_ready", {31'b0, id_ready}, 32'h0);
        step();
        clear_fwd();
        #1;
        check("bp_c2_scr_a", ex_scr_a, 32'h55);
        check("bp_c2_scr_b", ex_scr_b, 32'h22);
        step();
        check("bp_c3_scr_a", ex_scr_a, 32'h55);
        check("bp_c3_valid", {31'b0, ex_valid}, 32'h1);
        ex_ready = 1'b1;
        #1;
        check("bp_rel_scr_a", ex_scr_a, 32'h55);
        step();
        check("bp_gone", {31'b0, ex_valid}, 32'h0);

        // Shift: load into rs does not stall a shift
        load_instr(4'b1000, 5'd9, 32'hFFFF, 5'd3, 32'h1, 5'd4, 32'h0, 5'd4, 1'b0, 1'b1);
        step();
        id_valid = 1'b0;
        #1;
        check("sll_scr_a", ex_scr_a, 32'h1);
        check("sll_scr_b", ex_scr_b, 32'h4);
        check("sll_alu", {28'b0, ex_alu_control}, 32'h8);
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dest = 5'd9;
        #1;
        check("sll_no_lu", {31'b0, ex_valid}, 32'h1);
        clear_fwd();

        // Flush beats same-cycle accept; held data stays
        load_instr(4'b0000, 5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 32'h0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_keeps_alu", {28'b0, ex_alu_control}, 32'h8);

        // Flush while stalled by back-pressure
        load_instr(4'b0001, 5'd1, 32'h3, 5'd2, 32'h4, 5'd5, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_stall_pre", {31'b0, ex_valid}, 32'h1);
        step();
        flush = 1'b0;
        #1;
        check("fl_stall_post", {31'b0, ex_valid}, 32'h0);

        // Reset in the middle of a load-use stall
        ex_ready = 1'b1;
        load_instr(4'b0010, 5'd3, 32'h33, 5'd6, 32'h44, 5'd7, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_dest = 5'd6;
        #1;
        check("rst_stall_pre", {31'b0, ex_valid}, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_fwd();
        #1;
        check("rst_mid_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_mid_scr_a", ex_scr_a, 32'h0);
        check("rst_mid_regwr", {31'b0, ex_reg_write}, 32'h0);
        check("rst_mid_ready", {31'b0, id_ready}, 32'h1);
`ifdef EX_STALL_CNT_EN
        check("rst_mid_stall_cnt", {16'b0, stall_cnt}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
